// File: rtl/freq_display_driver.sv
// -----------------------------------------------------------------------------
// freq_display_driver
//
// Takes the 16-bit binary frequency word from the counter stage and converts it
// to 5-digit BCD with a sequential shift-add-3 (double-dabble) engine. The
// result drives a 4-digit common-anode 7-segment display through time
// multiplexing, with leading-zero blanking. Readings above 9999 drop the least
// significant decimal digit and light the decimal point on the rightmost digit
// as a x10 indicator.
//
// Ports:
//   mclk      : system clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset (release synchronous to mclk)
//   freq      : unsigned binary frequency, may change at any time
//   seg       : segment cathodes {g,f,e,d,c,b,a}, active low
//   dp        : decimal point cathode, active low
//   an        : digit anodes, active low, an[0] is the rightmost digit
//   bcd_out   : last completed conversion, [19:16] most significant nibble
//   conv_done : one-cycle pulse on the cycle bcd_out updates
// -----------------------------------------------------------------------------
module freq_display_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [15:0] freq,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [19:0] bcd_out,
  output logic        conv_done
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

  state_e      state_q, state_d;
  logic [15:0] last_freq_q, last_freq_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] acc_q, acc_d;
  logic [4:0]  iter_q, iter_d;
  logic [19:0] bcd_out_q, bcd_out_d;
  logic        conv_done_q, conv_done_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  digit_idx_q, digit_idx_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;

  logic [19:0] acc_adj;
  logic [35:0] shifted;
  logic        x10;
  logic [15:0] disp;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F; // non-decimal nibbles cannot occur; show blank
    endcase
  endfunction

  // Add-3 correction: any nibble >= 5 would exceed 9 after the coming shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    shifted = {acc_adj, bin_q} << 1;
  end

  // Conversion FSM
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    last_freq_d = last_freq_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    iter_d      = iter_q;
    bcd_out_d   = bcd_out_q;
    conv_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (freq != last_freq_q) begin
          last_freq_d = freq;
          bin_d       = freq;
          acc_d       = '0;
          iter_d      = 5'd16;
          state_d     = CONV;
        end
      end
      CONV: begin
        acc_d  = shifted[35:16];
        bin_d  = shifted[15:0];
        iter_d = iter_q - 5'd1;
        if (iter_q == 5'd1) state_d = LOAD;
      end
      LOAD: begin
        bcd_out_d   = acc_q;
        conv_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan and segment generation, always from the registered bcd_out.
  always_comb begin
    x10  = (bcd_out_q[19:16] != 4'd0);
    disp = x10 ? bcd_out_q[19:4] : bcd_out_q[15:0];
    nib  = disp[4*digit_idx_q +: 4];
    case (digit_idx_q)
      2'd3:    blank = (disp[15:12] == 4'd0);
      2'd2:    blank = (disp[15:8]  == 8'd0);
      2'd1:    blank = (disp[15:4]  == 12'd0);
      default: blank = 1'b0;   // rightmost digit is never blanked
    endcase
    seg_d = blank ? 7'h7F : seg_decode(nib);
    dp_d  = !(x10 && (digit_idx_q == 2'd0));
    an_d  = ~(4'b0001 << digit_idx_q);

    scan_cnt_d  = scan_cnt_q + 16'd1;
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_freq_q <= '0;
      bin_q       <= '0;
      acc_q       <= '0;
      iter_q      <= '0;
      bcd_out_q   <= '0;
      conv_done_q <= 1'b0;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      an_q        <= 4'hF;
    end else begin
      state_q     <= state_d;
      last_freq_q <= last_freq_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      iter_q      <= iter_d;
      bcd_out_q   <= bcd_out_d;
      conv_done_q <= conv_done_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign bcd_out   = bcd_out_q;
  assign conv_done = conv_done_q;

endmodule

// File: tb/tb_freq_display_driver.sv
module tb_freq_display_driver;

  localparam int SCAN_DIV = 4;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] freq = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [19:0] bcd_out;
  logic        conv_done;

  freq_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .mclk(mclk), .rst_n(rst_n), .freq(freq), .seg(seg), .dp(dp),
    .an(an), .bcd_out(bcd_out), .conv_done(conv_done)
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model helpers (decimal arithmetic).
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int div;
    div = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  function automatic void disp_model(input int n, input int idx,
                                     output logic [6:0] s, output logic d);
    int shown, p;
    shown = (n > 9999) ? n / 10 : n;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && shown < p) s = 7'h7F;
    else s = seg_tbl[(shown / p) % 10];
    d = (n > 9999 && idx == 0) ? 1'b0 : 1'b1;
  endfunction

  typedef struct { logic [19:0] bcd; int due; } exp_t;
  exp_t sb[$];

  // Behavioural model state
  int m_edge, m_cnt, m_idx, m_disp, m_last, m_next_cmp, m_pend_val, m_pend_due;
  bit m_pend;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;
  logic [3:0] e_an = 4'hF;

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge = 0; m_cnt = 0; m_idx = 0; m_disp = 0; m_last = 0;
      m_next_cmp = 0; m_pend = 0; m_pend_val = 0; m_pend_due = 0;
      sb.delete();
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end else begin
      m_edge++;
      disp_model(m_disp, m_idx, e_seg, e_dp);
      e_an = ~(4'b0001 << m_idx);
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else m_cnt++;
      if (m_pend && m_edge == m_pend_due) begin
        m_disp = m_pend_val;
        m_pend = 0;
      end
      if (m_edge >= m_next_cmp && int'(freq) != m_last) begin
        exp_t e;
        m_last = int'(freq);
        e.bcd = to_bcd(m_last);
        e.due = m_edge + 17;
        sb.push_back(e);
        m_pend = 1; m_pend_val = m_last; m_pend_due = m_edge + 17;
        m_next_cmp = m_edge + 18;
      end
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge mclk) begin
    logic exp_done;
    exp_done = rst_n && sb.size() > 0 && sb[0].due == m_edge;
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("an", 32'(an), 32'(e_an));
    check("bcd_out", 32'(bcd_out), 32'(to_bcd(m_disp)));
    check("conv_done", 32'(conv_done), 32'(exp_done));
    if (conv_done && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_bcd", 32'(bcd_out), 32'(e.bcd));
    end
  end

  task automatic set_freq(input int v, input int wait_cycles);
    @(negedge mclk);
    freq = 16'(v);
    repeat (wait_cycles) @(negedge mclk);
  endtask

  initial begin
    // Reset with freq = 0
    repeat (3) @(negedge mclk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    rst_n = 1'b1;
    repeat (40) @(negedge mclk);

    // Directed patterns
    set_freq(1234, 40);
    set_freq(7, 40);
    set_freq(65535, 40);
    set_freq(9999, 40);
    set_freq(10000, 40);

    // Mid-conversion change
    set_freq(100, 5);
    freq = 16'd200;
    repeat (60) @(negedge mclk);

    // Reset pulse during conversion
    set_freq(500, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'h7F);
    check("async_an", 32'(an), 32'hF);
    check("async_dp", 32'(dp), 32'h1);
    check("async_bcd", 32'(bcd_out), 32'h0);
    check("async_done", 32'(conv_done), 32'h0);
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    repeat (40) @(negedge mclk);

    // Randomized stimulus
    for (int i = 0; i < 40; i++) begin
      int v;
      case ($urandom_range(0, 5))
        0: v = 0;
        1: v = 65535;
        2: v = $urandom_range(0, 99);
        3: v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, 65535);
      endcase
      set_freq(v, $urandom_range(1, 40));
    end

    repeat (60) @(negedge mclk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_display_driver.md
Name: freq_display_driver

Overview:
- Downstream consumer of the 16-bit binary frequency word from the frequency counter.
- Converts the word to 5-digit BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives the Basys2 4-digit common-anode 7-segment display by time multiplexing, with leading-zero blanking.
- Readings above 9999 are shown with a x10 scale indicator.

Parameters:
- SCAN_DIV, 50000: mclk cycles per digit slot (1 ms at 50 MHz); legal range 2..65535.

Ports:
- mclk  in  1: system clock; all state on rising edge.
- rst_n  in  1: asynchronous active-low reset; assertion is asynchronous, release is synchronous to mclk.
- freq  in  16: unsigned binary frequency from the counter stage; may change at any time.
- seg  out  7: segment cathodes {g,f,e,d,c,b,a}, active low.
- dp  out  1: decimal point cathode, active low.
- an  out  4: digit anodes, active low; an[0] is the rightmost digit.
- bcd_out  out  20: last completed conversion, 5 BCD nibbles, [19:16] most significant.
- conv_done  out  1: one-cycle pulse when bcd_out updates.

Behaviour:
- Reset values, forced while rst_n=0 regardless of clock:
  - seg=7'h7F, dp=1, an=4'hF, bcd_out=0, conv_done=0.
  - Internal state: last_freq=0, state=IDLE, scan counter=0, digit index=0.
- FSM states: IDLE, CONV, LOAD.
- IDLE: at each edge, if freq != last_freq, capture freq into the shift register and into last_freq, clear the BCD accumulator, load iteration count 16, and go to CONV. Otherwise stay in IDLE.
- CONV: each edge runs one iteration. First add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1. Leave for LOAD after the 16th iteration.
- LOAD: bcd_out <= accumulator; conv_done=1 for this single cycle; return to IDLE.
- Latency: capture edge k, bcd_out and conv_done valid after edge k+17. Minimum spacing between successive conversions is 18 cycles.
- freq changes during CONV or LOAD are ignored. IDLE re-compares on return, so bcd_out always converges to the final stable freq.
- Display source is bcd_out:
  - If bcd_out[19:16]==0: digits 3..0 = bcd_out[15:0]; dp off on all digits.
  - Otherwise: digits 3..0 = bcd_out[19:4] (least significant decimal digit dropped); dp lit on digit 0 only (x10 indicator).
- Leading-zero blanking: digits 3, 2, 1 are blank when they and every more-significant displayed digit are 0. Digit 0 is never blanked. A blank digit drives seg=7'h7F.
- Segment codes (hex, active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Nibbles A-F cannot occur; decode them as blank.
- Scan counter: counts 0..SCAN_DIV-1 and wraps. On wrap, the digit index advances 0→1→2→3→0.
- an is one-hot low on the digit index (index 0 → 4'b1110).
- seg, dp and an are registered, updated every edge from the current index and display data. The first edge after reset release drives an=4'b1110.
- Digit switching is glitch-free: seg, dp and an change on the same edge.
- A bcd_out update takes effect on the next edge for the currently selected digit; no scan restart.
- Reset asserted mid-CONV or mid-LOAD:
  - Abort immediately and return to the reset values.
  - No conv_done.
  - After release, the IDLE compare against last_freq=0 restarts the conversion if freq != 0.

Test Plan:
- Reset then release with freq=0 (SCAN_DIV=4):
  - During reset: an=F, seg=7F, dp=1.
  - After release: an=E, seg=40; digits 1-3 show seg=7F when selected; each an value held 4 cycles, sequence E,D,B,7.
  - conv_done never fires.
- freq=1234 applied at edge k:
  - conv_done high exactly in cycle k+17; bcd_out=20'h01234.
  - Scanned segs: digit 0=19, digit 1=30, digit 2=24, digit 3=79; dp=1 throughout.
- freq=7: bcd_out=20'h00007; digit 0 seg=78; digits 1-3 seg=7F.
- freq=65535:
  - bcd_out=20'h65535.
  - Display 6553: digit 0=30, digit 1=12, digit 2=12, digit 3=02.
  - dp=0 only while an=E.
- Mid-conversion change:
  - freq=100, then freq=200 five cycles later.
  - First conv_done with bcd_out=20'h00100; a second conv_done 18 cycles later with bcd_out=20'h00200.
- Reset pulse during CONV with freq=500:
  - Outputs return to reset values asynchronously; no conv_done while rst_n=0.
  - After release, conv_done in cycle 17 after the first edge with bcd_out=20'h00500.
